// File: rtl/bcd_pkg.sv
// Shared BCD arithmetic types and helpers.
// Used by bcd_sub_serial and its digit cell.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [4:0] BCD_RADIX = 5'd10;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    COMP,
    DONE
  } bcd_sub_state_t;

  function automatic logic bcd_digit_valid(bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtractor with borrow.
// d = a - b - b_in, wrapped by +10 when negative.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       b_in,
  output bcd_digit_t d,
  output logic       b_o
);

  logic signed [4:0] diff;
  logic [4:0] adj;

  always_comb begin
    diff = $signed({1'b0, a}) - $signed({1'b0, b})
         - $signed({4'b0000, b_in});
    adj  = diff + BCD_RADIX;
    b_o  = diff[4];
    d    = b_o ? adj[3:0] : diff[3:0];
  end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor, LSD first, start/done handshake.
// BCD_SUB_MAG_EN adds a COMP pass so z holds |x - y|.
module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] x,
  input  logic [4*N_DIGITS-1:0] y,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] z,
  output logic                  b_out,
  output logic                  err
);

  localparam int W  = BCD_W * N_DIGITS;
  localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_DIGITS - 1);

  bcd_sub_state_t state;
  logic [W-1:0] xs;
  logic [W-1:0] ys;
  logic [W-1:0] acc;
  logic [W-1:0] acc_sh;
  logic [CW-1:0] cnt;
  logic borrow;
  logic err_q;
  logic bad;
  logic last;

  bcd_digit_t cell_a;
  bcd_digit_t cell_b;
  bcd_digit_t cell_d;
  logic cell_bo;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!bcd_digit_valid(x[i*BCD_W +: BCD_W]) ||
          !bcd_digit_valid(y[i*BCD_W +: BCD_W]))
        bad = 1'b1;
    end
  end

  // COMP reuses the cell as 0 - z to fold the result to magnitude
  always_comb begin
    cell_a = xs[BCD_W-1:0];
    cell_b = ys[BCD_W-1:0];
    if (state == COMP) begin
      cell_a = '0;
      cell_b = acc[BCD_W-1:0];
    end
  end

  bcd_digit_sub u_cell (
    .a    (cell_a),
    .b    (cell_b),
    .b_in (borrow),
    .d    (cell_d),
    .b_o  (cell_bo)
  );

  always_comb begin
    acc_sh = acc >> BCD_W;
    acc_sh[W-1 -: BCD_W] = cell_d;
  end

  assign last = (cnt == LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      xs     <= '0;
      ys     <= '0;
      acc    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      err_q  <= 1'b0;
      z      <= '0;
      b_out  <= 1'b0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            xs     <= x;
            ys     <= y;
            acc    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            err_q  <= bad;
            state  <= RUN;
          end
        end
        RUN: begin
          xs     <= xs >> BCD_W;
          ys     <= ys >> BCD_W;
          acc    <= acc_sh;
          borrow <= cell_bo;
          cnt    <= cnt + 1'b1;
          if (last) begin
`ifdef BCD_SUB_MAG_EN
            if (cell_bo) begin
              state  <= COMP;
              cnt    <= '0;
              borrow <= 1'b0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              z     <= err_q ? '0 : acc_sh;
              b_out <= 1'b0;
              err   <= err_q;
            end
`else
            state <= DONE;
            done  <= 1'b1;
            z     <= err_q ? '0 : acc_sh;
            b_out <= !err_q && cell_bo;
            err   <= err_q;
`endif
          end
        end
`ifdef BCD_SUB_MAG_EN
        COMP: begin
          acc    <= acc_sh;
          borrow <= cell_bo;
          cnt    <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            z     <= err_q ? '0 : acc_sh;
            b_out <= !err_q;
            err   <= err_q;
          end
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Self-checking bench for bcd_sub_serial with N_DIGITS=2.
// Table vectors, sweep, handshake and async reset sequences.
module tb_bcd_sub_serial;

  localparam int N = 2;
`ifdef BCD_SUB_MAG_EN
  localparam bit MAG = 1'b1;
`else
  localparam bit MAG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [4*N-1:0] x;
  logic [4*N-1:0] y;
  logic busy;
  logic done;
  logic [4*N-1:0] z;
  logic b_out;
  logic err;

  bcd_sub_serial #(.N_DIGITS(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .b_out (b_out),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] z;
    logic       b;
    logic       e;
  } exp_t;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
    logic       b;
    logic       e;
  } vec_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t r;
    int ai, bi, d;
    r.e = (a[3:0] > 9) || (a[7:4] > 9) || (b[3:0] > 9) || (b[7:4] > 9);
    ai = a[7:4] * 10 + a[3:0];
    bi = b[7:4] * 10 + b[3:0];
    d = ai - bi;
    r.b = !r.e && (d < 0);
    if (r.e) d = 0;
    else if (d < 0) d = MAG ? -d : d + 100;
    r.z = {4'(d / 10), 4'(d % 10)};
    return r;
  endfunction

  task automatic run_op(input logic [7:0] xa, input logic [7:0] ya,
                        input string tag);
    exp_t e, got;
    int lat, lat_exp, nbusy;
    bit seen;
    e = model(xa, ya);
    exp_q.push_back(e);
    lat_exp = (MAG && e.b) ? 2*N + 1 : N + 1;
    @(negedge clk);
    x = xa;
    y = ya;
    start = 1'b1;
    seen = 1'b0;
    nbusy = 0;
    lat = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        seen = 1'b1;
        lat = k;
      end
    end
    got = exp_q.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within 40 cycles", tag);
    end else begin
      check({tag, " z"}, 32'(z), 32'(got.z));
      check({tag, " b_out"}, 32'(b_out), 32'(got.b));
      check({tag, " err"}, 32'(err), 32'(got.e));
      check({tag, " latency"}, lat, lat_exp);
      check({tag, " busy cycles"}, nbusy, lat_exp);
      @(negedge clk);
      check({tag, " done pulse"}, 32'(done), 0);
      check({tag, " idle"}, 32'(busy), 0);
      check({tag, " z hold"}, 32'(z), 32'(got.z));
    end
  endtask

  vec_t vecs[8];

  initial begin
    exp_t e;
    bit seen;

    vecs[0] = '{8'h47, 8'h19, 8'h28, 1'b0, 1'b0};
    vecs[1] = '{8'h19, 8'h47, MAG ? 8'h28 : 8'h72, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h01, MAG ? 8'h01 : 8'h99, 1'b1, 1'b0};
    vecs[3] = '{8'h99, 8'h99, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h3A, 8'h01, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{8'h50, 8'h25, 8'h25, 1'b0, 1'b0};
    vecs[6] = '{8'h10, 8'h01, 8'h09, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h99, MAG ? 8'h99 : 8'h01, 1'b1, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    #1;
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset z", 32'(z), 0);
    check("reset b_out", 32'(b_out), 0);
    check("reset err", 32'(err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].x, vecs[i].y, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table z", i), 32'(z), 32'(vecs[i].z));
      check($sformatf("vec%0d table b", i), 32'(b_out), 32'(vecs[i].b));
      check($sformatf("vec%0d table e", i), 32'(err), 32'(vecs[i].e));
    end

    // Every digit pair appears in both digit positions
    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 10; b++)
        run_op({4'(a), 4'(b)}, {4'(b), 4'(a)}, $sformatf("sweep%0d%0d", a, b));

    for (int i = 0; i < 100; i++)
      run_op({4'($urandom_range(9)), 4'($urandom_range(9))},
             {4'($urandom_range(9)), 4'($urandom_range(9))},
             $sformatf("rand%0d", i));

    // start held with new operands while busy must be ignored
    e = model(8'h50, 8'h25);
    exp_q.push_back(e);
    @(negedge clk);
    x = 8'h50;
    y = 8'h25;
    start = 1'b1;
    @(negedge clk);
    x = 8'h11;
    y = 8'h99;
    seen = 1'b0;
    for (int k = 2; k <= 40 && !seen; k++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    start = 1'b0;
    e = exp_q.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL hs timeout: no done within 40 cycles");
    end else begin
      check("hs z", 32'(z), 32'(e.z));
      check("hs z const", 32'(z), 32'h25);
      check("hs b_out", 32'(b_out), 0);
      @(negedge clk);
      check("hs idle", 32'(busy), 0);
    end

    run_op(8'h47, 8'h19, "pre_rst");
    @(negedge clk);
    x = 8'h93;
    y = 8'h15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("midrun busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async busy", 32'(busy), 0);
    check("async done", 32'(done), 0);
    check("async z", 32'(z), 0);
    check("async b_out", 32'(b_out), 0);
    check("async err", 32'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h93, 8'h15, "post_rst");
    check("post_rst z const", 32'(z), 32'h78);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
